mult_iterative: RTL and testbench

//   Parametrised multi-cycle HI/LO multiplier; successor to the single-cycle combinational MULT unit.
//   - Signed/unsigned WIDTH x WIDTH -> 2*WIDTH product via magnitude shift-add, BPC bits per cycle.
//   - Start/ready/valid handshake; sits in the EX stage beside the divider.
//   - The pipeline stalls on o_busy and writes HI/LO on o_valid.

---
 rtl/mult_iterative.sv | 97 +++++++++
 tb/tb_mult_iterative.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mult_iterative.sv
// mult_iterative: multi-cycle signed/unsigned HI/LO shift-add multiplier, BPC bits per cycle; define MULT_ACC_EN for MADD/MSUB
module mult_iterative #(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_opr1,
  input  logic [WIDTH-1:0] i_opr2,
  input  logic             is_unsigned,
`ifdef MULT_ACC_EN
  input  logic [1:0]       i_acc_op,
`endif
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_hi_result,
  output logic [WIDTH-1:0] o_lo_result
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [W2-1:0]    r_acc, r_mcand, w_pp, w_mag, w_res;
  logic [WIDTH-1:0] r_mplier, w_abs1, w_abs2;
  logic [CW-1:0]    r_cnt;
  logic             r_neg, w_last, w_accept;
`ifdef MULT_ACC_EN
  logic [1:0]       r_acc_op;
`endif
  // Magnitudes in the unsigned view, so -2^(W-1) maps to 2^(W-1) without overflow
  assign w_abs1   = (!is_unsigned && i_opr1[WIDTH-1]) ? -i_opr1 : i_opr1;
  assign w_abs2   = (!is_unsigned && i_opr2[WIDTH-1]) ? -i_opr2 : i_opr2;
  assign w_accept = (r_state == IDLE) && i_start && !i_flush;
  // The multiplicand is pre-shifted each cycle, which equals shifting by cnt*BPC
  assign w_pp     = r_mcand * W2'(r_mplier[BPC-1:0]);
  assign w_last   = r_cnt == CW'(N - 1);
  assign w_mag    = r_neg ? -r_acc : r_acc;
`ifdef MULT_ACC_EN
  assign w_res    = (r_acc_op == 2'b01) ? {o_hi_result, o_lo_result} + w_mag :
                    (r_acc_op == 2'b10) ? {o_hi_result, o_lo_result} - w_mag : w_mag;
`else
  assign w_res    = w_mag;
`endif
  assign o_ready  = r_state == IDLE;
  assign o_busy   = r_state != IDLE;
  assign o_valid  = r_state == DONE;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  // Next state; flush always returns to IDLE and beats a simultaneous start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = i_start ? CALC : IDLE;
      CALC:    w_state_nxt = w_last ? FIX : CALC;
      FIX:     w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (i_flush) w_state_nxt = IDLE;
  end
  // Operand capture, shift-add iteration and result write on FIX->DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
`ifdef MULT_ACC_EN
      r_acc_op    <= 2'b00;
`endif
      o_hi_result <= '0;
      o_lo_result <= '0;
    end else begin
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= W2'(w_abs1);
        r_mplier <= w_abs2;
        r_cnt    <= '0;
        r_neg    <= !is_unsigned && (i_opr1[WIDTH-1] ^ i_opr2[WIDTH-1]);
`ifdef MULT_ACC_EN
        r_acc_op <= i_acc_op;
`endif
      end else if (r_state == CALC) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << BPC;
        r_mplier <= r_mplier >> BPC;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == FIX && !i_flush) {o_hi_result, o_lo_result} <= w_res;
    end
endmodule

// File: tb/tb_mult_iterative.sv
// tb_mult_iterative: vector table, multi-cycle corner sequences and random ops against an arithmetic model
module tb_mult_iterative;
  localparam int W   = 32;
  localparam int BPC = 2;
  localparam int LAT = W / BPC + 2;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         u;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_flush = 1'b0, is_unsigned = 1'b0;
  logic [W-1:0] i_opr1 = '0, i_opr2 = '0;
`ifdef MULT_ACC_EN
  logic [1:0] i_acc_op = 2'b00;
`endif
  logic o_ready, o_busy, o_valid;
  logic [W-1:0] o_hi_result, o_lo_result;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mult_iterative #(.WIDTH(W), .BPC(BPC)) dut (
`ifdef MULT_ACC_EN
    .i_acc_op(i_acc_op),
`endif
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flush(i_flush),
    .i_opr1(i_opr1), .i_opr2(i_opr2), .is_unsigned(is_unsigned),
    .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid),
    .o_hi_result(o_hi_result), .o_lo_result(o_lo_result)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    logic signed [2*W-1:0] sa, sb;
    if (u) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u, input int inj,
                        output logic [2*W-1:0] res, output int lat);
    @(negedge clk);
    check("ready_before_start", 64'(o_ready), 64'd1);
    check("valid_single_pulse", 64'(o_valid), 64'd0);
    i_opr1 = a; i_opr2 = b; is_unsigned = u; i_start = 1'b1;
    lat = 0;
    for (int k = 1; k <= LAT + 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
      if (k == inj) begin
        check("ready_low_in_calc", 64'(o_ready), 64'd0);
        i_opr1 = 3; i_opr2 = 3; is_unsigned = ~u; i_start = 1'b1;
      end
      if (k == inj + 1) i_start = 1'b0;
      if (o_valid) lat = k;
    end
    i_start = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL timeout: no o_valid within %0d cycles, required %0d", LAT + 20, LAT);
    end else check("latency", 64'(lat), 64'(LAT));
    check("ready_low_in_done", 64'(o_ready), 64'd0);
    res = {o_hi_result, o_lo_result};
  endtask
  task automatic expect_no_valid(input string name);
    logic seen = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask
  initial begin
    vec_t tbl [10];
    logic [W-1:0] corners [5];
    logic [2*W-1:0] res;
    logic [W-1:0] a, b;
    logic u;
    int lat;
    tbl = '{
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000},
      '{32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 32'h00000000},
      '{32'h00000001, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'hFFFFFFFF},
      '{32'h00000007, 32'h00000006, 1'b1, 32'h00000000, 32'h0000002A},
      '{32'h80000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h80000000},
      '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000},
      '{32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 32'h00000000}
    };
    corners = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(o_hi_result), 64'd0);
    check("reset_lo", 64'(o_lo_result), 64'd0);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].u, 0, res, lat);
      check($sformatf("tbl%0d_hi", i), 64'(res[2*W-1:W]), 64'(tbl[i].hi));
      check($sformatf("tbl%0d_lo", i), 64'(res[W-1:0]), 64'(tbl[i].lo));
    end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5, res, lat);
    check("busy_start_result", 64'(res), 64'hFFFFFFFE_00000001);
    @(negedge clk);
    check("busy_start_ready_after_done", 64'(o_ready), 64'd1);
    i_opr1 = 7; i_opr2 = 6; is_unsigned = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_to_idle", 64'(o_ready), 64'd1);
    expect_no_valid("flush_no_valid");
    check("flush_keeps_hilo", 64'({o_hi_result, o_lo_result}), 64'hFFFFFFFE_00000001);
    @(negedge clk);
    i_opr1 = 9; i_opr2 = 9; i_start = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    check("flush_beats_start", 64'(o_ready), 64'd1);
    expect_no_valid("flush_idle_no_valid");
    run_op(32'd11, 32'd13, 1'b1, 0, res, lat);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_in_done_keeps", 64'({o_hi_result, o_lo_result}), 64'd143);
    @(negedge clk);
    i_opr1 = 5; i_opr2 = 5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_hi", 64'(o_hi_result), 64'd0);
    check("reset_mid_lo", 64'(o_lo_result), 64'd0);
    check("reset_mid_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd7, 32'd6, 1'b1, 0, res, lat);
    check("after_reset_7x6", 64'(res), 64'h2A);
`ifdef MULT_ACC_EN
    run_op(32'd2, 32'd5, 1'b1, 0, res, lat);
    i_acc_op = 2'b10;
    run_op(32'd3, 32'd4, 1'b0, 0, res, lat);
    i_acc_op = 2'b00;
    check("msub", 64'(res), 64'hFFFFFFFF_FFFFFFFE);
`endif
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      u = 1'($urandom_range(0, 1));
      run_op(a, b, u, 0, res, lat);
      check($sformatf("rand %h*%h u=%0d", a, b, u), 64'(res), 64'(model(a, b, u)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
